// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lends one external (shared) adder to four requesters.
// Optional macro ADDER_ARBITER_STATS_EN adds a 16-bit completed-operation counter, op_count.
module adder_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   src1_i,
    input  logic [4*WIDTH-1:0]   src2_i,
    output logic [3:0]           gnt,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 carry,
    output logic [1:0]           res_id,
    output logic                 busy
`ifdef ADDER_ARBITER_STATS_EN
    ,
    output logic [15:0]          op_count
`endif
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [1:0]         ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         win_c;

    // First set request at or above the pointer, wrapping; downward scan lets the nearest win.
    always_comb begin
        win_c = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                win_c = ptr_q + 2'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            res_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            res_id    <= '0;
            busy      <= 1'b0;
`ifdef ADDER_ARBITER_STATS_EN
            op_count  <= '0;
`endif
        end else begin
            gnt <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= GRANT;
                        gnt     <= 4'b0001 << win_c;
                        res_id  <= win_c;
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    // Operands are taken from the winner only while its grant is showing.
                    add_a   <= src1_i[32'(res_id) * WIDTH +: WIDTH];
                    add_b   <= src2_i[32'(res_id) * WIDTH +: WIDTH];
                    ptr_q   <= res_id + 2'd1;
                    cnt_q   <= '0;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (cnt_q == CNT_W'(ADD_LAT - 1)) begin
                        result    <= add_sum;
                        carry     <= add_cout;
                        cnt_q     <= '0;
                        res_valid <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
`ifdef ADDER_ARBITER_STATS_EN
                        op_count  <= op_count + 16'd1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a cycle-timeline model of the arbitration rules, a per-cycle
// compare process, directed scenarios with literal expectations, and a random phase.
module tb_adder_arbiter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned ADD_LAT = 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           req;
    logic [4*WIDTH-1:0]   src1_i;
    logic [4*WIDTH-1:0]   src2_i;
    logic [3:0]           gnt;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic                 res_valid;
    logic                 res_ready;
    logic [WIDTH-1:0]     result;
    logic                 carry;
    logic [1:0]           res_id;
    logic                 busy;
`ifdef ADDER_ARBITER_STATS_EN
    logic [15:0]          op_count;
`endif

    adder_arbiter #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .carry     (carry),
        .res_id    (res_id),
        .busy      (busy)
`ifdef ADDER_ARBITER_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    // Shared adder: operands are held stable, so a combinational sum is valid in time.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    int n_vec  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: timeline since the grant edge ----------------
    logic [1:0]       m_ptr;
    logic [1:0]       m_id;
    logic [3:0]       m_gnt;
    logic             m_busy;
    logic             m_valid;
    logic             m_carry;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;
    logic [WIDTH-1:0] m_res;
    int               m_t;
    logic [15:0]      m_ops;

    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(int'(ptr) + k) % 4]) return 2'((int'(ptr) + k) % 4);
        end
        return ptr;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= '0; m_id <= '0; m_gnt <= '0; m_busy <= 1'b0; m_valid <= 1'b0;
            m_carry <= 1'b0; m_a <= '0; m_b <= '0; m_res <= '0; m_t <= 0; m_ops <= '0;
        end else begin
            m_gnt <= '0;
            if (!m_busy) begin
                if (|req) begin
                    m_gnt  <= 4'b0001 << rr_pick(m_ptr, req);
                    m_id   <= rr_pick(m_ptr, req);
                    m_busy <= 1'b1;
                    m_t    <= 0;
                end
            end else if (m_valid) begin
                if (res_ready) begin
                    m_valid <= 1'b0;
                    m_busy  <= 1'b0;
                    m_ops   <= m_ops + 16'd1;
                end
            end else begin
                m_t <= m_t + 1;
                if (m_t == 0) begin
                    m_a   <= src1_i[32'(m_id) * WIDTH +: WIDTH];
                    m_b   <= src2_i[32'(m_id) * WIDTH +: WIDTH];
                    m_ptr <= m_id + 2'd1;
                end
                if (m_t == int'(ADD_LAT)) begin
                    {m_carry, m_res} <= {1'b0, m_a} + {1'b0, m_b};
                    m_valid          <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every registered output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gnt",       64'(gnt),       64'(m_gnt));
            chk("busy",      64'(busy),      64'(m_busy));
            chk("res_valid", 64'(res_valid), 64'(m_valid));
            chk("res_id",    64'(res_id),    64'(m_id));
            chk("result",    64'(result),    64'(m_res));
            chk("carry",     64'(carry),     64'(m_carry));
            chk("add_a",     64'(add_a),     64'(m_a));
            chk("add_b",     64'(add_b),     64'(m_b));
`ifdef ADDER_ARBITER_STATS_EN
            chk("op_count",  64'(op_count),  64'(m_ops));
`endif
        end
    end

    task automatic wait_valid(input int lim);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (res_valid !== 1'b1 && i < lim);
        chk("wait_valid", 64'(res_valid), 64'(1));
    endtask

    task automatic wait_idle(input int lim);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (busy !== 1'b0 && i < lim);
        chk("wait_idle", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        req = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_src();
        src1_i = {$urandom, $urandom, $urandom, $urandom};
        src2_i = {$urandom, $urandom, $urandom, $urandom};
    endtask

    logic [3:0] gseq[$];
    int         gcyc[$];
    logic [WIDTH-1:0] held_res;

    initial begin
        rst_n = 1'b1; req = '0; src1_i = '0; src2_i = '0; res_ready = 1'b1;
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(res_valid), 64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // 5 + 3 from requester 0: grant on first edge, result on third.
        req = 4'b0001;
        src1_i[0 +: WIDTH] = 32'h0000_0005;
        src2_i[0 +: WIDTH] = 32'h0000_0003;
        @(negedge clk);
        chk("t1_gnt", 64'(gnt), 64'h1);
        chk("t1_busy", 64'(busy), 64'h1);
        #1 req = '0;
        @(negedge clk);
        chk("t1_gnt_pulse", 64'(gnt), 64'h0);
        chk("t1_add_a", 64'(add_a), 64'h5);
        @(negedge clk);
        chk("t1_valid", 64'(res_valid), 64'h1);
        chk("t1_result", 64'(result), 64'h8);
        chk("t1_carry", 64'(carry), 64'h0);
        chk("t1_id", 64'(res_id), 64'h0);
        @(negedge clk);
        chk("t1_done", 64'(res_valid), 64'h0);

        // All four requesting continuously from a fresh pointer.
        do_reset();
        req = 4'b1111;
        rand_src();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt != 4'b0000) begin
                gseq.push_back(gnt);
                gcyc.push_back(c);
            end
        end
        chk("t2_ngrants", 64'(gseq.size() >= 5), 64'h1);
        for (int k = 0; k < 5 && k < gseq.size(); k++) begin
            chk("t2_order", 64'(gseq[k]), 64'(4'b0001 << (k % 4)));
            if (k > 0) chk("t2_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'(ADD_LAT + 3));
        end
        #1 req = '0;
        wait_idle(20);

        // Overflow from requester 2.
        #1 req = 4'b0100;
        rand_src();
        src1_i[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
        src2_i[2*WIDTH +: WIDTH] = 32'h0000_0001;
        @(negedge clk);
        chk("t3_gnt", 64'(gnt), 64'h4);
        #1 req = '0;
        wait_valid(10);
        chk("t3_result", 64'(result), 64'h0);
        chk("t3_carry", 64'(carry), 64'h1);
        chk("t3_id", 64'(res_id), 64'h2);
        wait_idle(5);

        // Back-pressure: RESP holds while inputs churn.
        #1 res_ready = 1'b0;
        req = 4'b0001;
        rand_src();
        src1_i[0 +: WIDTH] = 32'h0000_1234;
        src2_i[0 +: WIDTH] = 32'h0000_1111;
        @(negedge clk);
        #1 req = '0;
        wait_valid(10);
        chk("t4_result", 64'(result), 64'h2345);
        held_res = result;
        repeat (5) begin
            #1 req = 4'($urandom_range(0, 15));
            rand_src();
            @(negedge clk);
            chk("t4_hold_valid", 64'(res_valid), 64'h1);
            chk("t4_hold_result", 64'(result), 64'(held_res));
            chk("t4_hold_id", 64'(res_id), 64'h0);
            chk("t4_no_gnt", 64'(gnt), 64'h0);
        end
        #1 res_ready = 1'b1;
        req = '0;
        @(negedge clk);
        chk("t4_release_valid", 64'(res_valid), 64'h0);
        chk("t4_release_busy", 64'(busy), 64'h0);

        // Reset in the middle of EXEC.
        #1 req = 4'b0010;
        src1_i[WIDTH +: WIDTH] = 32'h0000_AAAA;
        src2_i[WIDTH +: WIDTH] = 32'h0000_5555;
        @(negedge clk);
        chk("t5_gnt", 64'(gnt), 64'h2);
        #1 req = '0;
        @(negedge clk);
        chk("t5_add_a", 64'(add_a), 64'hAAAA);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'h0);
        chk("t5_rst_add_a", 64'(add_a), 64'h0);
        chk("t5_rst_result", 64'(result), 64'h0);
        chk("t5_rst_id", 64'(res_id), 64'h0);
        chk("t5_rst_valid", 64'(res_valid), 64'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_valid", 64'(res_valid), 64'h0);
        end
        #1 req = 4'b1000;
        @(negedge clk);
        chk("t5_gnt_after", 64'(gnt), 64'h8);
        #1 req = '0;
        wait_idle(10);

        // Random traffic, judged by the per-cycle compare.
        repeat (400) begin
            #1 req = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            res_ready = ($urandom_range(0, 3) != 0);
            rand_src();
            @(negedge clk);
        end
        #1 req = '0;
        res_ready = 1'b1;
        wait_idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter: ADD_LAT, default 1, cycles the shared adder needs from operand-valid to sum-valid; legal range 1..7.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester add request; requester holds it high until it sees its gnt bit.
REQ-006 src1_i  input  4*WIDTH  packed operand A; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-007 src2_i  input  4*WIDTH  packed operand B, same packing.
REQ-008 gnt  output  4  one-hot grant, single-cycle pulse.
REQ-009 add_a, add_b  output  WIDTH each  registered operands driven to the shared adder.
REQ-010 add_sum  input  WIDTH  sum returned by the shared adder.
REQ-011 add_cout  input  1  carry returned by the shared adder.
REQ-012 res_valid  output  1  result valid.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 result  output  WIDTH  captured sum.
REQ-015 carry  output  1  captured carry.
REQ-016 res_id  output  2  index of the requester that owns the result.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, GRANT, EXEC and RESP.
REQ-019 IDLE -> GRANT SHALL occur when any req bit is high; otherwise the FSM stays in IDLE.
REQ-020 On entering GRANT, the winner SHALL be the first set req bit found searching upward (with wrap) from the round-robin pointer.
REQ-021 In GRANT, gnt[winner] SHALL be high for exactly one cycle, add_a/add_b SHALL latch the winner's operand slices, and res_id SHALL latch the winner index.
REQ-022 The round-robin pointer SHALL become (winner+1) mod 4 at the end of GRANT.
REQ-023 EXEC SHALL last exactly ADD_LAT cycles, counted by an internal 3-bit counter.
REQ-024 On the last EXEC cycle, add_sum and add_cout SHALL be captured into result and carry, and the FSM SHALL move to RESP.
REQ-025 In RESP, res_valid SHALL be high, and result, carry and res_id SHALL be held stable until res_ready is sampled high.
REQ-026 RESP with res_ready high SHALL go to IDLE next cycle, with res_valid low.
REQ-027 Issue-to-result latency SHALL be ADD_LAT+2 cycles from the first req-high edge in IDLE to the first res_valid-high cycle.
REQ-028 Throughput SHALL be at most one operation per ADD_LAT+3 cycles.
REQ-029 req changes during GRANT, EXEC or RESP SHALL NOT affect the operation in flight.
REQ-030 Operand inputs SHALL be sampled only in GRANT; later changes SHALL NOT alter add_a or add_b.
REQ-031 add_a and add_b SHALL hold their values until the next GRANT.
REQ-032 Width rule: result SHALL be exactly WIDTH bits, with the overflow bit reported only on carry.

Reset
REQ-033 While rst_n is low, all of the following SHALL hold immediately (asynchronous, including mid-operation):
  - state = IDLE, pointer = 0, EXEC counter = 0;
  - gnt = 0, res_valid = 0, busy = 0;
  - result = 0, carry = 0, res_id = 0, add_a = 0, add_b = 0.
REQ-034 An operation interrupted by reset SHALL be discarded, with no res_valid after reset release.
REQ-035 The first arbitration after reset SHALL start its search from requester 0.

Configuration
REQ-036 Macro ADDER_ARBITER_STATS_EN, when defined, SHALL add an output op_count (16 bits) that increments by 1 on each RESP-to-IDLE handshake, wraps from 0xFFFF to 0x0000, and resets to 0.
REQ-037 Without ADDER_ARBITER_STATS_EN, op_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 ADD_LAT=1: req=0001, src1[0]=0x00000005, src2[0]=0x00000003 -> gnt=0001 for one cycle; res_valid on the 3rd edge; result=0x00000008, carry=0, res_id=0.
REQ-039 req=1111 held continuously with res_ready=1 -> grants in order 0001, 0010, 0100, 1000, 0001, one every 4 cycles.
REQ-040 Operands 0xFFFFFFFF + 0x00000001 from requester 2 -> result=0x00000000, carry=1, res_id=2.
REQ-041 res_ready=0 for 5 cycles in RESP, with src inputs and req toggling -> res_valid, result and res_id held stable; no new gnt; IDLE one cycle after res_ready=1.
REQ-042 rst_n pulled low during EXEC -> outputs reset immediately; after release, no res_valid; next req=1000 is granted 1000.
REQ-043 ADDER_ARBITER_STATS_EN defined, 3 completed operations -> op_count=3; preload to 0xFFFF and complete 1 more -> op_count=0.
